// File: rtl/bus_mem_responder_pkg.sv
// Shared types for the bus memory responder: bus word/pointer types,
// responder FSM states and the latched request record.
package bus_mem_responder_pkg;

    // Word address and data word on the external bus.
    typedef logic [29:0] ptr;
    typedef logic [31:0] word;

    // Responder FSM states.
    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StRespond
    } bus_resp_state;

    // Request fields captured on accept.
    typedef struct packed {
        ptr   addr;
        logic write;
        word  data;
    } bus_req;

    // Window decode: wrap-around subtraction so addresses below base
    // become huge offsets and fall out of range.
    function automatic logic ptr_in_window(ptr addr, ptr base, int unsigned words);
        ptr off;
        off = addr - base;
        return off < ptr'(words);
    endfunction

endpackage

// File: rtl/bus_mem_responder_if.sv
// Initiator/target bus between the core's fetch/load-store unit and a
// memory responder.
interface bus_mem_responder_if;

    bus_mem_responder_pkg::ptr  bus_addr;
    logic                       bus_start;
    logic                       bus_write;
    bus_mem_responder_pkg::word bus_data_wr;
    logic                       bus_ready;
    bus_mem_responder_pkg::word bus_data_rd;

    modport master (
        output bus_addr,
        output bus_start,
        output bus_write,
        output bus_data_wr,
        input  bus_ready,
        input  bus_data_rd
    );

    modport slave (
        input  bus_addr,
        input  bus_start,
        input  bus_write,
        input  bus_data_wr,
        output bus_ready,
        output bus_data_rd
    );

endinterface

// File: rtl/bus_mem_array.sv
// Single-port synchronous RAM: one access per enabled cycle, read data
// registered and valid the cycle after a read access.
module bus_mem_array
    import bus_mem_responder_pkg::*;
#(
    parameter int unsigned WORDS  = 4096,
    parameter int unsigned ADDR_W = (WORDS > 1) ? $clog2(WORDS) : 1
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  word               wdata,
    output word               rdata
);

    word mem [WORDS];

    // Storage and read register; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/bus_mem_responder.sv
// Word-addressed memory responder on the external bus. Each accepted
// request is latched, held for WAIT_CYCLES cycles, then answered with a
// single-cycle bus_ready pulse carrying read data or a write ack.
module bus_mem_responder
    import bus_mem_responder_pkg::*;
#(
    parameter int unsigned MEM_WORDS   = 4096,
    parameter ptr          BASE        = 30'h0,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    bus_mem_responder_if.slave    bus,
    output logic                  overrun
);

    localparam int unsigned IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT =
        (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

    bus_resp_state    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    bus_req           req_q, req_d;
    logic             overrun_q, overrun_d;

    bus_req           in_req;
    bus_req           acc_req;
    logic             accept;
    logic             access;
    ptr               acc_off;
    logic             acc_in_range;
    logic             resp_in_range;
    logic             mem_en;
    logic [IDX_W-1:0] mem_idx;
    word              mem_rdata;

    assign in_req = '{addr: bus.bus_addr, write: bus.bus_write, data: bus.bus_data_wr};

    // A new request is legal only when nothing is in flight or in the
    // response cycle itself (back-to-back).
    assign accept = bus.bus_start && ((state_q == StIdle) || (state_q == StRespond));

    // Next-state, wait counter and access-point strobe.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        access  = 1'b0;
        unique case (state_q)
            StIdle, StRespond: begin
                state_d = StIdle;
                if (accept) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d = StRespond;
                        access  = 1'b1;
                    end else begin
                        state_d = StWait;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            StWait: begin
                if (cnt_q == '0) begin
                    state_d = StRespond;
                    access  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Request latch and sticky overrun flag next-state.
    always_comb begin
        req_d     = req_q;
        overrun_d = overrun_q;
        if (accept) begin
            req_d = in_req;
        end
        if (bus.bus_start && !accept) begin
            overrun_d = 1'b1;
        end
    end

    // FSM, counter, request and overrun registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            req_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            req_q     <= req_d;
            overrun_q <= overrun_d;
        end
    end

    // With zero wait states the access happens in the accept cycle, before
    // the request has been latched, so it must use the live bus fields.
    assign acc_req      = (WAIT_CYCLES == 0) ? in_req : req_q;
    assign acc_off      = acc_req.addr - BASE;
    assign acc_in_range = ptr_in_window(acc_req.addr, BASE, MEM_WORDS);
    assign mem_idx      = acc_off[IDX_W-1:0];

    // Gated by rst_n so nothing is written while reset is held.
    assign mem_en = access && acc_in_range && rst_n;

    bus_mem_array #(
        .WORDS  (MEM_WORDS),
        .ADDR_W (IDX_W)
    ) u_array (
        .clk   (clk),
        .en    (mem_en),
        .we    (acc_req.write),
        .addr  (mem_idx),
        .wdata (acc_req.data),
        .rdata (mem_rdata)
    );

    // During RESPOND the latch still holds the request being answered,
    // even if a new one is accepted in the same cycle.
    assign resp_in_range = ptr_in_window(req_q.addr, BASE, MEM_WORDS);

    // Response outputs: ready only in RESPOND, data forced to zero otherwise.
    always_comb begin
        bus.bus_ready   = (state_q == StRespond);
        bus.bus_data_rd = '0;
        if ((state_q == StRespond) && !req_q.write && resp_in_range) begin
            bus.bus_data_rd = mem_rdata;
        end
    end

    assign overrun = overrun_q;

endmodule

// File: tb/tb_bus_mem_responder.sv
// Scoreboard bench for bus_mem_responder: two instances (2 wait states with
// window at 0x1000, and 0 wait states with window at 0). Expected responses
// with their due cycle are queued at issue time and checked by monitors.
module tb_bus_mem_responder;

    localparam int WA = 2;
    localparam int WB = 0;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   errors;
    logic overrun_a;
    logic overrun_b;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea;
    exp_t eb;

    bus_mem_responder_if ifa ();
    bus_mem_responder_if ifb ();

    bus_mem_responder #(
        .MEM_WORDS   (4096),
        .BASE        (30'h1000),
        .WAIT_CYCLES (WA)
    ) dut_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (ifa.slave),
        .overrun (overrun_a)
    );

    bus_mem_responder #(
        .MEM_WORDS   (4096),
        .BASE        (30'h0),
        .WAIT_CYCLES (WB)
    ) dut_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (ifb.slave),
        .overrun (overrun_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Monitor for instance a.
    always @(negedge clk) begin
        checks++;
        if (ifa.bus_ready === 1'b1) begin
            if (qa.size() == 0) begin
                errors++;
                $display("FAIL a_unexpected_ready: ready=1 at cycle %0d, expected no response", cyc);
            end else begin
                ea = qa.pop_front();
                if (ifa.bus_data_rd !== ea.data || cyc != ea.cyc) begin
                    errors++;
                    $display("FAIL a_response: got data %h at cycle %0d, expected %h at cycle %0d",
                             ifa.bus_data_rd, cyc, ea.data, ea.cyc);
                end
            end
        end else if (ifa.bus_data_rd !== 32'h0) begin
            errors++;
            $display("FAIL a_idle_data: got %h while ready=0, expected 0", ifa.bus_data_rd);
        end
    end

    // Monitor for instance b.
    always @(negedge clk) begin
        checks++;
        if (ifb.bus_ready === 1'b1) begin
            if (qb.size() == 0) begin
                errors++;
                $display("FAIL b_unexpected_ready: ready=1 at cycle %0d, expected no response", cyc);
            end else begin
                eb = qb.pop_front();
                if (ifb.bus_data_rd !== eb.data || cyc != eb.cyc) begin
                    errors++;
                    $display("FAIL b_response: got data %h at cycle %0d, expected %h at cycle %0d",
                             ifb.bus_data_rd, cyc, eb.data, eb.cyc);
                end
            end
        end else if (ifb.bus_data_rd !== 32'h0) begin
            errors++;
            $display("FAIL b_idle_data: got %h while ready=0, expected 0", ifb.bus_data_rd);
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called just after a posedge; pulses bus_start for this cycle only.
    task automatic issue(input int sel, input logic [29:0] addr, input logic wr,
                         input logic [31:0] wd, input logic [31:0] exp, input bit want);
        exp_t e;
        if (sel == 0) begin
            ifa.bus_addr = addr; ifa.bus_write = wr; ifa.bus_data_wr = wd; ifa.bus_start = 1'b1;
        end else begin
            ifb.bus_addr = addr; ifb.bus_write = wr; ifb.bus_data_wr = wd; ifb.bus_start = 1'b1;
        end
        if (want) begin
            e.data = exp;
            e.cyc  = cyc + ((sel == 0) ? WA : WB) + 1;
            if (sel == 0) qa.push_back(e);
            else qb.push_back(e);
        end
        @(posedge clk);
        #1;
        ifa.bus_start = 1'b0;
        ifb.bus_start = 1'b0;
        // Scramble fields so the DUT must rely on its own latch.
        ifa.bus_addr = 30'h3FFF_FFFF; ifa.bus_write = 1'b0; ifa.bus_data_wr = 32'hA5A5_A5A5;
        ifb.bus_addr = 30'h3FFF_FFFF; ifb.bus_write = 1'b0; ifb.bus_data_wr = 32'hA5A5_A5A5;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((qa.size() != 0 || qb.size() != 0) && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (qa.size() != 0 || qb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d/%0d responses still pending, expected 0/0",
                     qa.size(), qb.size());
            qa.delete();
            qb.delete();
        end
    endtask

    task automatic xfer(input int sel, input logic [29:0] addr, input logic wr,
                        input logic [31:0] wd, input logic [31:0] exp);
        issue(sel, addr, wr, wd, exp, 1'b1);
        drain();
    endtask

    initial begin
        cyc    = 0;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        ifa.bus_start = 1'b0; ifa.bus_addr = '0; ifa.bus_write = 1'b0; ifa.bus_data_wr = '0;
        ifb.bus_start = 1'b0; ifb.bus_addr = '0; ifb.bus_write = 1'b0; ifb.bus_data_wr = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ready_a", {31'h0, ifa.bus_ready}, 32'h0);
        check("reset_data_a", ifa.bus_data_rd, 32'h0);
        check("reset_overrun_a", {31'h0, overrun_a}, 32'h0);
        check("reset_ready_b", {31'h0, ifb.bus_ready}, 32'h0);
        check("reset_data_b", ifb.bus_data_rd, 32'h0);
        check("reset_overrun_b", {31'h0, overrun_b}, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);

        // Zero wait states: write, read back, then back-to-back write->read->read.
        issue(1, 30'h4, 1'b1, 32'h1234_5678, 32'h0, 1'b1);
        idle(2);
        issue(1, 30'h4, 1'b0, 32'h0, 32'h1234_5678, 1'b1);
        idle(2);
        issue(1, 30'h8, 1'b1, 32'hCAFE_F00D, 32'h0, 1'b1);
        issue(1, 30'h8, 1'b0, 32'h0, 32'hCAFE_F00D, 1'b1);
        issue(1, 30'h4, 1'b0, 32'h0, 32'h1234_5678, 1'b1);
        drain();
        check("b_no_overrun_b2b", {31'h0, overrun_b}, 32'h0);

        // Two wait states: write then read, then back-to-back in RESPOND.
        xfer(0, 30'h1010, 1'b1, 32'hDEAD_BEEF, 32'h0);
        xfer(0, 30'h1010, 1'b0, 32'h0, 32'hDEAD_BEEF);
        issue(0, 30'h1020, 1'b1, 32'h0BAD_F00D, 32'h0, 1'b1);
        idle(2);
        issue(0, 30'h1020, 1'b0, 32'h0, 32'h0BAD_F00D, 1'b1);
        drain();
        check("a_no_overrun_b2b", {31'h0, overrun_a}, 32'h0);

        // Window edges and out-of-range accesses that would alias if undecoded.
        xfer(0, 30'h1000, 1'b1, 32'h1111_0000, 32'h0);
        xfer(0, 30'h1FFF, 1'b1, 32'h2222_0FFF, 32'h0);
        xfer(0, 30'h2000, 1'b1, 32'h3333_3333, 32'h0);
        xfer(0, 30'h0FFF, 1'b0, 32'h0, 32'h0);
        xfer(0, 30'h1000, 1'b0, 32'h0, 32'h1111_0000);
        xfer(0, 30'h1FFF, 1'b0, 32'h0, 32'h2222_0FFF);
        xfer(0, 30'h1010, 1'b0, 32'h0, 32'hDEAD_BEEF);

        // Overrun: a second start during WAIT is ignored and sets the flag.
        issue(0, 30'h1010, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b1);
        issue(0, 30'h1000, 1'b1, 32'h5555_5555, 32'h0, 1'b0);
        drain();
        idle(3);
        check("a_overrun_set", {31'h0, overrun_a}, 32'h1);
        check("b_overrun_clear", {31'h0, overrun_b}, 32'h0);
        xfer(0, 30'h1000, 1'b0, 32'h0, 32'h1111_0000);
        check("a_overrun_sticky", {31'h0, overrun_a}, 32'h1);

        // Reset one cycle before the expected ready abandons the write.
        xfer(0, 30'h1030, 1'b1, 32'h1111_1111, 32'h0);
        issue(0, 30'h1030, 1'b1, 32'h2222_2222, 32'h0, 1'b0);
        idle(1);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_mid_ready", {31'h0, ifa.bus_ready}, 32'h0);
        check("rst_mid_overrun", {31'h0, overrun_a}, 32'h0);
        idle(2);
        @(negedge clk);
        check("rst_hold_ready", {31'h0, ifa.bus_ready}, 32'h0);
        check("rst_hold_data", ifa.bus_data_rd, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);
        xfer(0, 30'h1030, 1'b0, 32'h0, 32'h1111_1111);
        xfer(1, 30'h4, 1'b0, 32'h0, 32'h1234_5678);
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1);
    end

endmodule
